// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//
// Minutes:seconds countdown timer with BCD time registers. A prescaler
// divides clk down to one decrement per DIV cycles while running. The
// preset is loaded by strobe and checked for legal BCD; an illegal preset
// is rejected and flagged on the sticky load_err output.
//
// Parameters
//   DIV       clk cycles per one-second decrement
//
// Ports
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset
//   load      strobe: load preset (highest priority)
//   load_min  BCD minutes preset {tens, ones}, 00-99
//   load_sec  BCD seconds preset {tens, ones}, 00-59
//   start     strobe: start or resume counting (lowest priority)
//   pause     strobe: pause counting
//   min       current BCD minutes
//   sec       current BCD seconds
//   running   high while counting
//   done      high once the count has reached 00:00
//   load_err  sticky flag, set by an illegal preset, cleared by a legal one
// ---------------------------------------------------------------------------
module countdown_timer #(
  parameter int DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  // A one-bit prescaler is kept even for DIV=1 so the vector is never empty.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [7:0]    min_nxt;
  logic [7:0]    sec_nxt;
  logic          err_nxt;
  logic          running_nxt;
  logic          done_nxt;
  logic          preset_ok;
  logic          tick;
  logic          last_second;
  logic          time_zero;
  logic [15:0]   time_dec;

  // One-second BCD decrement of {min, sec} with the borrow rippling from
  // seconds ones through seconds tens (base 6) into the minutes digits.
  // Only used while running, where the time is never 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic       borrow;
    {m1, m0, s1, s0} = t;
    borrow = 1'b1;
    if (s0 != 4'd0) begin
      s0     = s0 - 4'd1;
      borrow = 1'b0;
    end else begin
      s0 = 4'd9;
    end
    if (borrow) begin
      if (s1 != 4'd0) begin
        s1     = s1 - 4'd1;
        borrow = 1'b0;
      end else begin
        s1 = 4'd5;
      end
    end
    if (borrow) begin
      if (m0 != 4'd0) begin
        m0     = m0 - 4'd1;
        borrow = 1'b0;
      end else begin
        m0 = 4'd9;
      end
    end
    if (borrow) begin
      m1 = m1 - 4'd1;
    end
    return {m1, m0, s1, s0};
  endfunction

  // Preset legality: every digit 0-9 and seconds tens 0-5.
  assign preset_ok = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                     (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);

  assign tick        = (presc == PRESC_MAX);
  assign time_dec    = bcd_dec({min, sec});
  assign last_second = (min == 8'h00) && (sec == 8'h01);
  assign time_zero   = (min == 8'h00) && (sec == 8'h00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath decisions. Strobe priority is load, then pause,
  // then start; a pause strobe swallows a simultaneous start even when the
  // pause itself has no effect. Pausing freezes the prescaler for that edge
  // so a resume continues exactly where the count left off.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    min_nxt   = min;
    sec_nxt   = sec;
    err_nxt   = load_err;
    if (load) begin
      if (preset_ok) begin
        state_nxt = IDLE;
        min_nxt   = load_min;
        sec_nxt   = load_sec;
        presc_nxt = '0;
        err_nxt   = 1'b0;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (pause) begin
      if (state == RUN) begin
        state_nxt = PAUSED;
      end
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (start) begin
            state_nxt = time_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (tick) begin
            presc_nxt          = '0;
            {min_nxt, sec_nxt} = time_dec;
            if (last_second) begin
              state_nxt = DONE;
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decoded from the next state so that, once registered,
  // they change on the same edge as the state itself.
  always_comb begin
    running_nxt = (state_nxt == RUN);
    done_nxt    = (state_nxt == DONE);
  end

  // Time, prescaler, error flag and status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      min      <= 8'h00;
      sec      <= 8'h00;
      load_err <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      presc    <= presc_nxt;
      min      <= min_nxt;
      sec      <= sec_nxt;
      load_err <= err_nxt;
      running  <= running_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//
// Self-checking bench for countdown_timer with DIV=4. A behavioural model
// keeps the time as a plain number of seconds and the prescaler as an
// integer; a compare process checks every DUT output against it on each
// falling edge. Directed sequences add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int DIV = 4;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load = 1'b0;
  logic [7:0] load_min = 8'h00;
  logic [7:0] load_sec = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] min;
  logic [7:0] sec;
  logic       running;
  logic       done;
  logic       load_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  int m_state = M_IDLE;
  int m_secs  = 0;
  int m_presc = 0;
  bit m_err   = 1'b0;

  countdown_timer #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .min      (min),
    .sec      (sec),
    .running  (running),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] b;
    b[7:4] = 4'(n / 10);
    b[3:0] = 4'(n % 10);
    return b;
  endfunction

  function automatic bit preset_legal(input logic [7:0] m, input logic [7:0] s);
    return (m[7:4] < 4'd10) && (m[3:0] < 4'd10) && (s[7:4] < 4'd6) && (s[3:0] < 4'd10);
  endfunction

  // Behavioural model: time held as total seconds, state as a small integer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = M_IDLE;
      m_secs  = 0;
      m_presc = 0;
      m_err   = 1'b0;
    end else if (load) begin
      if (preset_legal(load_min, load_sec)) begin
        m_secs  = bcd2int(load_min) * 60 + bcd2int(load_sec);
        m_state = M_IDLE;
        m_presc = 0;
        m_err   = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else if (pause) begin
      if (m_state == M_RUN) m_state = M_PAUSED;
    end else if (start && (m_state == M_IDLE || m_state == M_PAUSED)) begin
      m_state = (m_secs == 0) ? M_DONE : M_RUN;
    end else if (m_state == M_RUN) begin
      m_presc = (m_presc + 1) % DIV;
      if (m_presc == 0) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) m_state = M_DONE;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      n_tests++;
      if (min !== int2bcd(m_secs / 60) || sec !== int2bcd(m_secs % 60) ||
          running !== (m_state == M_RUN) || done !== (m_state == M_DONE) ||
          load_err !== m_err) begin
        n_fail++;
        $display("[TB] FAIL model @%0t: got %h:%h run=%b done=%b err=%b, want %h:%h run=%b done=%b err=%b",
                 $time, min, sec, running, done, load_err,
                 int2bcd(m_secs / 60), int2bcd(m_secs % 60),
                 (m_state == M_RUN), (m_state == M_DONE), m_err);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] em, input logic [7:0] es,
                             input logic er, input logic ed, input logic ee);
    n_tests++;
    if ({min, sec, running, done, load_err} !== {em, es, er, ed, ee}) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h:%h run=%b done=%b err=%b, want %h:%h run=%b done=%b err=%b",
               name, min, sec, running, done, load_err, em, es, er, ed, ee);
    end
  endtask

  // Drive one cycle of strobes; returns 1 time unit after the capturing edge.
  task automatic applyStimulus(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                               input logic st, input logic pa);
    load     = ld;
    load_min = lm;
    load_sec = ls;
    start    = st;
    pause    = pa;
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of sequence, want finish before time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    wait_cycles(1);
    checkOutput("idle after reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic countdown 00:03.
    applyStimulus(1'b1, 8'h00, 8'h03, 1'b0, 1'b0);
    checkOutput("load 00:03", 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("start running", 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    wait_cycles(3);
    checkOutput("no decrement at 3", 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    wait_cycles(1);
    checkOutput("sec 02 at 4", 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    wait_cycles(4);
    checkOutput("sec 01 at 8", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    wait_cycles(4);
    checkOutput("done at 12", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_cycles(6);
    checkOutput("done holds", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    // Borrow chains.
    applyStimulus(1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_cycles(4);
    checkOutput("01:00 -> 00:59", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h10, 8'h00, 1'b0, 1'b0);
    checkOutput("load 10:00 while running", 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_cycles(4);
    checkOutput("10:00 -> 09:59", 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);

    // Pause holds the prescaler; resume continues from it.
    applyStimulus(1'b1, 8'h00, 8'h05, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_cycles(4);
    checkOutput("00:05 -> 04", 8'h00, 8'h04, 1'b1, 1'b0, 1'b0);
    wait_cycles(2);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput("paused", 8'h00, 8'h04, 1'b0, 1'b0, 1'b0);
    wait_cycles(10);
    checkOutput("paused holds", 8'h00, 8'h04, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("resume", 8'h00, 8'h04, 1'b1, 1'b0, 1'b0);
    wait_cycles(1);
    checkOutput("resume +1", 8'h00, 8'h04, 1'b1, 1'b0, 1'b0);
    wait_cycles(1);
    checkOutput("resume +2 sec 03", 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);

    // Zero preset and preset validation.
    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    checkOutput("load 00:00", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("start at 00:00 -> done", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_cycles(5);
    checkOutput("done no decrement", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h1A, 8'h00, 1'b0, 1'b0);
    checkOutput("bad min 1A", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'h00, 8'h07, 1'b0, 1'b0);
    checkOutput("good load clears err", 8'h00, 8'h07, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h60, 1'b0, 1'b0);
    checkOutput("bad sec 60", 8'h00, 8'h07, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h02, 8'h30, 1'b0, 1'b0);
    checkOutput("good load 02:30", 8'h02, 8'h30, 1'b0, 1'b0, 1'b0);

    // Strobe priority.
    applyStimulus(1'b1, 8'h00, 8'h09, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_cycles(2);
    applyStimulus(1'b1, 8'h03, 8'h15, 1'b1, 1'b1);
    checkOutput("load wins", 8'h03, 8'h15, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    checkOutput("start+pause in idle", 8'h03, 8'h15, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);
    checkOutput("idle holds", 8'h03, 8'h15, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count.
    applyStimulus(1'b1, 8'h00, 8'h30, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_cycles(6);
    checkOutput("00:30 -> 00:29", 8'h00, 8'h29, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset immediate", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("held in reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    wait_cycles(2);
    checkOutput("idle after release", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    checkOutput("start after reset -> done", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    wait_cycles(8);
    checkOutput("reload and run to done", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have one parameter: DIV, default 50000000, clk cycles per one-second decrement; the bench SHALL override it to 4.
REQ-002 The block SHALL have port clk, input, 1, the single system clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port load, input, 1, a strobe that loads the preset value.
REQ-005 The block SHALL have port load_min, input, 8, the BCD minutes preset, {tens, ones}, valid range 00-99.
REQ-006 The block SHALL have port load_sec, input, 8, the BCD seconds preset, {tens, ones}, valid range 00-59.
REQ-007 The block SHALL have port start, input, 1, a strobe that starts or resumes the count.
REQ-008 The block SHALL have port pause, input, 1, a strobe that pauses the count.
REQ-009 The block SHALL have port min, output, 8, the current BCD minutes.
REQ-010 The block SHALL have port sec, output, 8, the current BCD seconds.
REQ-011 The block SHALL have port running, output, 1, high while in state RUN.
REQ-012 The block SHALL have port done, output, 1, high while in state DONE.
REQ-013 The block SHALL have port load_err, output, 1, sticky flag set when an invalid preset is presented.

Function
REQ-014 The block SHALL implement four states (IDLE, RUN, PAUSED, DONE) with registered outputs only.
REQ-015 Strobe priority within one cycle SHALL be load > pause > start.
REQ-016 On load with valid BCD, the block SHALL on the next edge set min/sec to the preset, clear load_err, clear the prescaler, and enter IDLE from any state.
REQ-017 On load with invalid BCD (any digit >9, or seconds tens >5), the block SHALL leave min/sec and state unchanged and set load_err on the next edge.
REQ-018 On start in IDLE or PAUSED, the block SHALL enter RUN on the next edge if min:sec != 00:00, otherwise enter DONE.
REQ-019 On start in RUN or DONE, the block SHALL have no effect.
REQ-020 On pause in RUN, the block SHALL enter PAUSED, and the prescaler value SHALL be held, not cleared.
REQ-021 On pause in any other state, the block SHALL have no effect.
REQ-022 The prescaler SHALL count 0..DIV-1 only in RUN; at DIV-1 it SHALL wrap to 0 and the time SHALL decrement by one second on that same edge.
REQ-023 Entering RUN from IDLE SHALL give the first decrement exactly DIV cycles after the start edge; resuming from PAUSED SHALL continue from the held prescaler value.
REQ-024 Decrement SHALL be BCD with borrow: seconds ones 0->9 with borrow to tens; seconds tens 0->5 with borrow to minutes; minutes borrow likewise through ones and tens.
REQ-025 When a decrement produces 00:00, the block SHALL enter DONE on the same edge, and min/sec SHALL hold 00:00 with no wrap to 99:59.
REQ-026 In DONE, the block SHALL hold min/sec; only load or reset SHALL exit DONE.
REQ-027 In IDLE, PAUSED and DONE, min/sec SHALL never change except via load.
REQ-028 running SHALL be high exactly in RUN, and done exactly in DONE, with no glitch cycles between states.

Reset
REQ-029 While rst_n=0, asynchronously and regardless of clk, the block SHALL set state IDLE, min=8'h00, sec=8'h00, prescaler=0, running=0, done=0, load_err=0.
REQ-030 Reset mid-count SHALL discard all count state; after release, the block SHALL be IDLE at 00:00 and require load then start.
REQ-031 After rst_n rises, the first active edge SHALL obey REQ-015..REQ-027 normally.

Verification
REQ-032 The bench SHALL cover: DIV=4, load 00:03, start -> running at next edge; sec 02/01/00 at cycles 4/8/12 after start; done=1 and running=0 at cycle 12, holding 00:00 thereafter.
REQ-033 The bench SHALL cover: load 01:00, start, wait 4 cycles -> min=00, sec=59 (both borrows); load 10:00 then one decrement -> 09:59.
REQ-034 The bench SHALL cover: load 00:05, start, pause at cycle 6 for 10 cycles, start -> next decrement at cycle 2 after resume (prescaler held), sec=04 then 03.
REQ-035 The bench SHALL cover: load 00:00, start -> done=1 next edge, no decrement; load 8'h1A or sec 8'h60 -> load_err=1, min/sec unchanged; a following valid load -> load_err=0.
REQ-036 The bench SHALL cover: load, start, and pause asserted together while RUN -> load wins, IDLE at the new preset; start+pause together in IDLE -> no state change.
REQ-037 The bench SHALL cover: rst_n pulsed low between clock edges during RUN at 00:30 -> outputs zero immediately, not at the next edge; after release, IDLE at 00:00.
